prod_accumulator: RTL

- Sequential stage directly downstream of the 4x3 array multiplier.
- Consumes the multiplier's 7-bit unsigned product stream through a valid/ready handshake and accumulates groups of N products, forming a dot-product result.
- Presents each group sum on a held output with a valid/ready handshake, then restarts.

---
 rtl/prod_acc_pkg.sv | 18 +
 rtl/prod_accumulator_if.sv | 33 +++
 rtl/acc_add_sat.sv | 33 +++
 rtl/prod_accumulator.sv | 113 +++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared types and default sizing for the product accumulator.
//   PROD_W_DEF : default product width (4x3 multiplier output)
//   N_DEF      : default products per group
//   ACC_W_DEF  : default accumulator / result width
//   CNT_W      : width of the in-group product counter (supports N up to 255)
package prod_acc_pkg;

   localparam int PROD_W_DEF = 7;
   localparam int N_DEF      = 8;
   localparam int ACC_W_DEF  = 12;
   localparam int CNT_W      = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// prod_accumulator_if: product input stream and group-sum output stream.
//   prod_in / in_valid / in_ready      : product stream from the multiplier
//   sum_out / out_valid / out_ready    : held group sum to downstream
//   ovf                                : sticky overflow flag
//   cnt_out                            : products accepted in current group
// Modports: master drives products and out_ready; slave is the accumulator.
interface prod_accumulator_if
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) ();

   logic [PROD_W-1:0] prod_in;
   logic              in_valid;
   logic              in_ready;
   logic [ACC_W-1:0]  sum_out;
   logic              out_valid;
   logic              out_ready;
   logic              ovf;
   logic [CNT_W-1:0]  cnt_out;

   modport master (
      output prod_in, in_valid, out_ready,
      input  in_ready, sum_out, out_valid, ovf, cnt_out
   );

   modport slave (
      input  prod_in, in_valid, out_ready,
      output in_ready, sum_out, out_valid, ovf, cnt_out
   );

endinterface

// File: rtl/acc_add_sat.sv
// acc_add_sat: combinational ACC_W+1 bit adder of accumulator plus
// zero-extended product.
//   acc_i   : current accumulator value
//   prod_i  : incoming product
//   sum_o   : next accumulator value (wrapped, or clamped when saturating)
//   carry_o : carry out of bit ACC_W-1
// Build option: PROD_ACC_SAT_EN clamps sum_o to all-ones on carry instead of
// wrapping modulo 2^ACC_W.
module acc_add_sat #(
   parameter int PROD_W = 7,
   parameter int ACC_W  = 12
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              carry_o
);

   logic [ACC_W:0] full_sum;

   always_comb begin
      full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
      carry_o  = full_sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
      // Once clamped, any further non-zero product carries again and re-clamps,
      // so the value stays pinned at max for the rest of the group.
      sum_o    = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
      sum_o    = full_sum[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: accumulates groups of N products from the 4x3 multiplier
// and presents each group sum on a held valid/ready output.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   clr  : synchronous clear of partial group, ovf and output
//   bus  : prod_accumulator_if.slave (product stream in, sum stream out)
// Build option: PROD_ACC_SAT_EN selects saturating instead of wrapping sums.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting products, in_ready=1, out_valid=0
// HOLD  | group sum presented on sum_out, waiting for out_ready
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int N      = N_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   prod_accumulator_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic               in_ready;
   logic               accept;
   logic [ACC_W-1:0]   add_sum;
   logic               add_carry;

   acc_add_sat #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .acc_i   (acc_q),
      .prod_i  (bus.prod_in),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   // clr drops a coincident product, so ready is withdrawn that cycle.
   assign in_ready = (state_q == ACCUM) && !clr && !rst;
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.sum_out   = sum_q;
   assign bus.ovf       = ovf_q;
   assign bus.cnt_out   = cnt_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (accept) begin
                  ovf_d = ovf_q | add_carry;
                  if (cnt_q == CNT_LAST) begin
                     sum_d   = add_sum;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     acc_d = add_sum;
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
